// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction fetch stage:
// FSM state encodings, the NOP encoding and PC helpers.
package inst_fetch_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_ENC = 32'h0000_0013;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] align_pc(
        input logic [31:0] a
    );
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding request to imem, a registered
// instruction slot for decode, and redirect/flush handling on branchEn.
// Ports: clk, rst (async, active-low); imem_req/addr/gnt/valid/rdata;
//        branchEn/branchTarget; stall; inst/inst_valid/pc; misalignErr.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_ENC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        branchEn,
    input  logic [31:0] branchTarget,
    input  logic        stall,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic        misalignErr
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic         accept;
    logic         consume;

    // Only request when the slot will be free at the accept edge,
    // so a response can always be loaded.
    assign imem_req  = rst & (state == S_REQ) & (~inst_valid | ~stall);
    assign imem_addr = fetch_pc;
    assign accept    = imem_req & imem_gnt;
    assign consume   = inst_valid & ~stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_REQ;
            fetch_pc    <= RESET_PC;
            pc          <= RESET_PC;
            inst        <= NOP_INST;
            inst_valid  <= 1'b0;
            misalignErr <= 1'b0;
        end else if (branchEn) begin
            // Redirect wins over load and consume.
            fetch_pc    <= align_pc(branchTarget);
            inst        <= NOP_INST;
            inst_valid  <= 1'b0;
            misalignErr <= |branchTarget[1:0];
            // Any request still in flight must be drained in FLUSH.
            unique case (state)
                S_REQ:   state <= accept ? S_FLUSH : S_REQ;
                S_WAIT,
                S_FLUSH: state <= imem_valid ? S_REQ : S_FLUSH;
                default: state <= S_REQ;
            endcase
        end else begin
            misalignErr <= 1'b0;
            if (consume) begin
                inst_valid <= 1'b0;
            end
            unique case (state)
                S_REQ: begin
                    if (accept) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        inst       <= imem_rdata;
                        pc         <= fetch_pc;
                        inst_valid <= 1'b1;
                        fetch_pc   <= fetch_pc + PC_STEP;
                        state      <= S_REQ;
                    end
                end
                S_FLUSH: begin
                    if (imem_valid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch with a variable-latency memory
// and an epoch-based reference model of the fetch stream.
module tb_inst_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          NCYC = 4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        branchEn = 1'b0;
    logic [31:0] branchTarget = '0;
    logic        stall = 1'b0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic        misalignErr;

    inst_fetch #(
        .RESET_PC(RPC),
        .NOP_INST(NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .branchEn    (branchEn),
        .branchTarget(branchTarget),
        .stall       (stall),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .pc          (pc),
        .misalignErr (misalignErr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Reference model: fetch stream with an epoch that every redirect
    // bumps; a response is kept only if its request's epoch is current.
    logic [31:0] m_next, m_oaddr, m_inst, m_pc;
    bit          m_out, m_valid, m_mis;
    int          m_ep, m_oep;

    // Memory: one pending request, random latency.
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;

    task automatic model_reset();
        m_next   = RPC;
        m_pc     = RPC;
        m_inst   = NOP;
        m_valid  = 0;
        m_mis    = 0;
        m_out    = 0;
        m_ep     = 0;
        m_oep    = 0;
        mem_pend = 0;
        mem_cnt  = 0;
    endtask

    task automatic model_step();
        bit req, acc, rsp;
        req = !m_out && (!m_valid || !stall);
        acc = req && imem_gnt;
        rsp = m_out && imem_valid;
        if (acc) begin
            m_out   = 1;
            m_oaddr = m_next;
            m_oep   = m_ep;
        end
        if (branchEn) begin
            m_ep++;
            m_next  = branchTarget & ~32'd3;
            m_valid = 0;
            m_inst  = NOP;
            m_mis   = (branchTarget % 4) != 0;
            if (rsp) m_out = 0;
        end else begin
            m_mis = 0;
            if (m_valid && !stall) m_valid = 0;
            if (rsp) begin
                m_out = 0;
                if (m_oep == m_ep) begin
                    m_inst  = mem_word(m_oaddr);
                    m_pc    = m_oaddr;
                    m_valid = 1;
                    m_next  = m_oaddr + 32'd4;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_req;
        exp_req = rst && !m_out && (!m_valid || !stall);
        check("imem_req",    {31'd0, imem_req},    {31'd0, exp_req});
        check("imem_addr",   imem_addr,            m_next);
        check("inst",        inst,                 m_inst);
        check("inst_valid",  {31'd0, inst_valid},  {31'd0, m_valid});
        check("pc",          pc,                   m_pc);
        check("misalignErr", {31'd0, misalignErr}, {31'd0, m_mis});
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0202;
            2:       return 32'hFFFF_FFFC;
            3:       return 32'hFFFF_FFF8;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int stall_pct, br_pct, gnt_pct;
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            check_outputs();
            case ((cyc / 400) % 5)
                0: begin stall_pct = 10; br_pct = 5;  gnt_pct = 100; end
                1: begin stall_pct = 60; br_pct = 10; gnt_pct = 60;  end
                2: begin stall_pct = 20; br_pct = 30; gnt_pct = 80;  end
                3: begin stall_pct = 0;  br_pct = 0;  gnt_pct = 100; end
                default: begin stall_pct = 40; br_pct = 15; gnt_pct = 40; end
            endcase
            imem_gnt     = ($urandom_range(0, 99) < gnt_pct);
            stall        = ($urandom_range(0, 99) < stall_pct);
            branchEn     = ($urandom_range(0, 99) < br_pct);
            branchTarget = pick_target();
            if ((cyc % 700) == 350 || (cyc % 700) == 351) begin
                if (rst) begin
                    rst = 1'b0;
                    #1;
                    check("rst_req",   {31'd0, imem_req},   32'd0);
                    check("rst_inst",  inst,                NOP);
                    check("rst_valid", {31'd0, inst_valid}, 32'd0);
                end
                rst        = 1'b0;
                imem_valid = 1'b0;
                model_reset();
                continue;
            end
            rst = 1'b1;
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(mem_addr);
                    mem_pend   = 0;
                end
            end
            #1;
            if (imem_req && imem_gnt) begin
                mem_pend = 1;
                mem_addr = imem_addr;
                mem_cnt  = $urandom_range(1, 3);
            end
            model_step();
        end
        @(negedge clk);
        check_outputs();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
